dram_loader: RTL

DRAM_LOADER -- requirements
Module: dram_loader

---
 rtl/dram_loader_pkg.sv | 46 ++++
 rtl/dram_word_pack.sv | 27 ++
 rtl/dram_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dram_loader_pkg.sv
// Shared definitions for the diagnostic DRAM loader: subfunction codes,
// FSM states, the packed DRAM word layout and the staged half-word record.
package dram_loader_pkg;

    typedef enum logic [2:0] {
        SF_EVEN_XY  = 3'b000,
        SF_ODD_XY   = 3'b001,
        SF_J_COMMON = 3'b010,
        SF_EVEN_J   = 3'b011,
        SF_ODD_J    = 3'b100,
        SF_PAIR     = 3'b101,
        SF_COMMIT   = 3'b110,
        SF_CLEAR    = 3'b111
    } subfunc_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_EVEN = 2'd1,
        WR_ODD  = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int ADDR_W       = 9;
    localparam int PAIR_W       = 8;
    localparam int DIN_W        = 15;

    // Field offsets within dram_din, counted from bit 0 (the MSB).
    localparam int DIN_A_POS    = 0;
    localparam int DIN_B_POS    = 3;
    localparam int DIN_P_POS    = 6;
    localparam int DIN_J14_POS  = 7;
    localparam int DIN_J710_POS = 11;
    localparam int DIN_XY_W     = 3;
    localparam int DIN_J_W      = 4;

    // Everything that differs between the even and odd word of a pair.
    typedef struct packed {
        logic [0:2] a;
        logic [0:2] b;
        logic       p;
        logic [0:3] j710;
    } half_t;

    localparam half_t HALF_ZERO = '0;

endpackage

// File: rtl/dram_word_pack.sv
// Assembles one DRAM word from its staged fields and reports whether the
// resulting 15-bit word carries odd (good) parity.
module dram_word_pack
    import dram_loader_pkg::*;
(
    input  logic [0:2]  a_i,
    input  logic [0:2]  b_i,
    input  logic        p_i,
    input  logic [0:3]  j14_i,
    input  logic [0:3]  j710_i,
    output logic [0:14] word_o,
    output logic        par_ok_o
);

    always_comb begin
        word_o                              = '0;
        word_o[DIN_A_POS    +: DIN_XY_W]    = a_i;
        word_o[DIN_B_POS    +: DIN_XY_W]    = b_i;
        word_o[DIN_P_POS]                   = p_i;
        word_o[DIN_J14_POS  +: DIN_J_W]     = j14_i;
        word_o[DIN_J710_POS +: DIN_J_W]     = j710_i;
    end

    // P is passed through untouched, so a deliberately bad P shows up here.
    assign par_ok_o = ^word_o;

endmodule

// File: rtl/dram_loader.sv
// Diagnostic loader: stages DRAM fields from EBUS strobes and commits them as
// an even/odd word pair with a fixed four-cycle write sequence.
module dram_loader
    import dram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        diag_load,
    input  logic [4:6]  diag_func,
    input  logic [0:35] ebus_data,
    output logic [0:8]  dram_addr,
    output logic [0:14] dram_din,
    output logic        dram_we,
    output logic        busy,
    output logic        done,
    output logic        par_err,
    output logic        overrun
);

    state_e      state_q,   state_d;
    half_t       even_q,    even_d;
    half_t       odd_q,     odd_d;
    logic [0:3]  j14_q,     j14_d;
    logic [0:7]  pair_q,    pair_d;
    logic [0:8]  addr_q,    addr_d;
    logic [0:14] din_q,     din_d;
    logic        we_q,      we_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        par_err_q, par_err_d;
    logic        overrun_q, overrun_d;

    half_t       pack_half;
    logic [0:14] pack_word;
    logic        pack_par_ok;
    logic        unused_ebus;

    assign unused_ebus = ^ebus_data[8:35];

    // The packer always prepares the word for the write cycle that follows.
    assign pack_half = (state_q == WR_EVEN) ? odd_q : even_q;

    dram_word_pack u_pack (
        .a_i      (pack_half.a),
        .b_i      (pack_half.b),
        .p_i      (pack_half.p),
        .j14_i    (j14_q),
        .j710_i   (pack_half.j710),
        .word_o   (pack_word),
        .par_ok_o (pack_par_ok)
    );

    always_comb begin
        state_d   = state_q;
        even_d    = even_q;
        odd_d     = odd_q;
        j14_d     = j14_q;
        pair_d    = pair_q;
        busy_d    = busy_q;
        par_err_d = par_err_q;
        overrun_d = overrun_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        din_d     = '0;

        case (state_q)
            IDLE: begin
                if (diag_load) begin
                    case (subfunc_e'(diag_func))
                        SF_EVEN_XY: begin
                            even_d.a = ebus_data[0:2];
                            even_d.b = ebus_data[3:5];
                            even_d.p = ebus_data[6];
                        end
                        SF_ODD_XY: begin
                            odd_d.a = ebus_data[0:2];
                            odd_d.b = ebus_data[3:5];
                            odd_d.p = ebus_data[6];
                        end
                        SF_J_COMMON: j14_d       = ebus_data[0:3];
                        SF_EVEN_J:   even_d.j710 = ebus_data[0:3];
                        SF_ODD_J:    odd_d.j710  = ebus_data[0:3];
                        SF_PAIR:     pair_d      = ebus_data[0:7];
                        SF_COMMIT: begin
                            state_d = WR_EVEN;
                            busy_d  = 1'b1;
                            we_d    = 1'b1;
                            din_d   = pack_word;
                        end
                        SF_CLEAR: begin
                            even_d    = HALF_ZERO;
                            odd_d     = HALF_ZERO;
                            j14_d     = '0;
                            pair_d    = '0;
                            par_err_d = 1'b0;
                            overrun_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            WR_EVEN: begin
                state_d = WR_ODD;
                we_d    = 1'b1;
                din_d   = pack_word;
            end
            WR_ODD: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                pair_d  = pair_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // Loads arriving mid-sequence are dropped and only leave a trace here.
        if (diag_load && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        if (we_d && !pack_par_ok) begin
            par_err_d = 1'b1;
        end

        if (state_d == WR_EVEN) begin
            addr_d = {pair_q, 1'b0};
        end else if (state_d == WR_ODD) begin
            addr_d = {pair_q, 1'b1};
        end else begin
            addr_d = {pair_d, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            even_q    <= HALF_ZERO;
            odd_q     <= HALF_ZERO;
            j14_q     <= '0;
            pair_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            even_q    <= even_d;
            odd_q     <= odd_d;
            j14_q     <= j14_d;
            pair_q    <= pair_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign dram_addr = addr_q;
    assign dram_din  = din_q;
    assign dram_we   = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign par_err   = par_err_q;
    assign overrun   = overrun_q;

endmodule
